// File: rtl/simm_refresh_arbiter.sv
// SIMM RAS/CAS owner: arbitrates CPU cycles against periodic CAS-before-RAS refresh; SIMM_REFRESH_STATS_EN adds refresh_count.
// Latency: cpu_grant is combinational from cpu_cs in IDLE/CPU; strobes decode directly from the state register.
// Backpressure: cpu_hold stretches the CPU cycle while refresh owns the SIMM; ticks queue up to PENDING_MAX.
module simm_refresh_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 312,
  parameter int unsigned RAS_CYCLES       = 3,
  parameter int unsigned PRECHARGE_CYCLES = 2,
  parameter int unsigned PENDING_MAX      = 4
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        cpu_cs,
  input  logic        overrun_clear,
  output logic        cpu_grant,
  output logic        cpu_hold,
  output logic [3:0]  refresh_ras,
  output logic [3:0]  refresh_cas,
  output logic        refresh_busy,
  output logic [2:0]  pending,
  output logic        overrun
`ifdef SIMM_REFRESH_STATS_EN
  ,
  output logic [15:0] refresh_count
`endif
);

  localparam logic [15:0] PRESCALE_RELOAD = 16'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]  RAS_LOAD        = 4'(RAS_CYCLES - 1);
  localparam logic [3:0]  PRE_LOAD        = 4'(PRECHARGE_CYCLES - 1);
  localparam logic [2:0]  PEND_MAX        = 3'(PENDING_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU,
    ST_CAS,
    ST_RAS,
    ST_PRE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic [2:0]  pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic [3:0]  dwell_q, dwell_d;
  logic        tick;
  logic        ras_done;
  logic        urgent;

  always_comb begin
    tick        = (prescaler_q == 16'd0);
    prescaler_d = tick ? PRESCALE_RELOAD : prescaler_q - 16'd1;
  end

  assign urgent = (pending_q == PEND_MAX);

  // A tick and a completed CBR in the same cycle cancel; a set always beats overrun_clear.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (overrun_clear) begin
      overrun_d = 1'b0;
    end
    if (tick && !ras_done) begin
      if (urgent) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end else if (!tick && ras_done) begin
      pending_d = pending_q - 3'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    cpu_grant    = 1'b0;
    refresh_ras  = 4'h0;
    refresh_cas  = 4'h0;
    refresh_busy = 1'b0;
    ras_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_cs && !urgent) begin
          cpu_grant = 1'b1;
          state_d   = ST_CPU;
        end else if (pending_q != 3'd0) begin
          state_d = ST_CAS;
        end
      end
      ST_CPU: begin
        if (cpu_cs) begin
          cpu_grant = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAS: begin
        refresh_cas  = 4'hF;
        refresh_busy = 1'b1;
        state_d      = ST_RAS;
        dwell_d      = RAS_LOAD;
      end
      ST_RAS: begin
        refresh_ras  = 4'hF;
        refresh_cas  = 4'hF;
        refresh_busy = 1'b1;
        if (dwell_q == 4'd0) begin
          ras_done = 1'b1;
          state_d  = ST_PRE;
          dwell_d  = PRE_LOAD;
        end else begin
          dwell_d = dwell_q - 4'd1;
        end
      end
      ST_PRE: begin
        refresh_busy = 1'b1;
        if (dwell_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cpu_hold = cpu_cs & ~cpu_grant;
  assign pending  = pending_q;
  assign overrun  = overrun_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      prescaler_q <= PRESCALE_RELOAD;
      pending_q   <= 3'd0;
      overrun_q   <= 1'b0;
      dwell_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      dwell_q     <= dwell_d;
    end
  end

`ifdef SIMM_REFRESH_STATS_EN
  logic [15:0] refresh_count_q, refresh_count_d;

  always_comb begin
    refresh_count_d = ras_done ? refresh_count_q + 16'd1 : refresh_count_q;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      refresh_count_q <= 16'd0;
    end else begin
      refresh_count_q <= refresh_count_d;
    end
  end

  assign refresh_count = refresh_count_q;
`endif

endmodule

// File: tb/tb_simm_refresh_arbiter.sv
// Directed bench for simm_refresh_arbiter: per-cycle expectations from pattern strings go through a scoreboard queue.
module tb_simm_refresh_arbiter;

  logic        clock = 1'b0;
  logic        n_reset;
  logic        cpu_cs;
  logic        overrun_clear;
  logic        cpu_grant;
  logic        cpu_hold;
  logic [3:0]  refresh_ras;
  logic [3:0]  refresh_cas;
  logic        refresh_busy;
  logic [2:0]  pending;
  logic        overrun;
`ifdef SIMM_REFRESH_STATS_EN
  logic [15:0] refresh_count;
`endif

  always #5 clock = ~clock;

  simm_refresh_arbiter #(
    .REFRESH_INTERVAL(8),
    .RAS_CYCLES(3),
    .PRECHARGE_CYCLES(2),
    .PENDING_MAX(4)
  ) dut (
    .clock(clock),
    .n_reset(n_reset),
    .cpu_cs(cpu_cs),
    .overrun_clear(overrun_clear),
    .cpu_grant(cpu_grant),
    .cpu_hold(cpu_hold),
    .refresh_ras(refresh_ras),
    .refresh_cas(refresh_cas),
    .refresh_busy(refresh_busy),
    .pending(pending),
    .overrun(overrun)
`ifdef SIMM_REFRESH_STATS_EN
    ,
    .refresh_count(refresh_count)
`endif
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [15:0] vec;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic string rep(string s, int n);
    string r;
    r = "";
    for (int k = 0; k < n; k++) r = {r, s};
    return r;
  endfunction

  task automatic compare_front(logic [15:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %h required an expectation entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.vec) else begin
        mismatched++;
        $error("FAIL %s cyc %0d: observed %h required %h", e.tag, e.cyc, obs, e.vec);
      end
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] expv);
    exp_t e;
    e.tag = tag;
    e.cyc = -1;
    e.vec = expv;
    sb.push_back(e);
    compare_front(obs);
  endtask

  task automatic do_reset();
    n_reset       = 1'b0;
    cpu_cs        = 1'b0;
    overrun_clear = 1'b0;
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
  endtask

  // Codes per cycle: I idle/ungranted, G granted, H held in IDLE, C cas, R ras+cas, P precharge.
  // Expected vector = {0, grant, hold, ras, cas, busy, pending, overrun}.
  task automatic run_seq(string tag, string cs_p, string st_p, string pd_p, string clr_p, string ov_p);
    for (int i = 0; i < st_p.len(); i++) begin
      exp_t        e;
      logic        c;
      logic        g;
      logic        r;
      logic        cs_on;
      logic        ov;
      logic [2:0]  p;
      byte         s;
      s  = st_p.getc(i);
      c  = (cs_p.getc(i) == "1");
      g  = (s == "G");
      r  = (s == "R");
      cs_on = (s == "C") || (s == "R");
      ov = (i < ov_p.len()) && (ov_p.getc(i) == "1");
      p  = 3'(pd_p.getc(i) - 8'd48);
      cpu_cs        = c;
      overrun_clear = (i < clr_p.len()) && (clr_p.getc(i) == "1");
      e.tag = tag;
      e.cyc = i;
      e.vec = {1'b0, g, c && !g, r ? 4'hF : 4'h0, cs_on ? 4'hF : 4'h0,
               cs_on || (s == "P"), p, ov};
      sb.push_back(e);
      #2;
      compare_front({1'b0, cpu_grant, cpu_hold, refresh_ras, refresh_cas,
                     refresh_busy, pending, overrun});
      @(negedge clock);
    end
    cpu_cs        = 1'b0;
    overrun_clear = 1'b0;
  endtask

  initial begin
    // Reset state, checked while n_reset is still low.
    n_reset       = 1'b0;
    cpu_cs        = 1'b0;
    overrun_clear = 1'b0;
    #7;
    chk("reset_outputs", {1'b0, cpu_grant, cpu_hold, refresh_ras, refresh_cas,
                          refresh_busy, pending, overrun}, 16'h0000);

    // Idle bus: first tick, one full CBR, next tick.
    do_reset();
    run_seq("idle_cbr", rep("0", 18),
            {rep("I", 9), rep("C", 1), rep("R", 3), rep("P", 2), rep("I", 2), rep("C", 1)},
            {rep("0", 8), rep("1", 5), rep("0", 3), rep("1", 2)}, "", "");
`ifdef SIMM_REFRESH_STATS_EN
    chk("count_after_one", refresh_count, 16'd1);
`endif

    // Tick lands on the RAS->PRE cycle: pending holds at 1, a second CBR follows.
    do_reset();
    run_seq("tick_on_done", {rep("1", 10), rep("0", 10)},
            {rep("G", 10), rep("I", 2), rep("C", 1), rep("R", 3), rep("P", 2), rep("I", 1), rep("C", 1)},
            {rep("0", 8), rep("1", 12)}, "", "");

    // CPU owns the SIMM for 20 cycles; queued refreshes run once cs drops.
    do_reset();
    run_seq("cpu_20", {rep("1", 20), rep("0", 10)},
            {rep("G", 20), rep("I", 2), rep("C", 1), rep("R", 3), rep("P", 2), rep("I", 1), rep("C", 1)},
            {rep("0", 8), rep("1", 8), rep("2", 8), rep("3", 2), rep("2", 4)}, "", "");

    // Long CPU ownership: pending saturates, overrun sets, urgent CBR holds the CPU,
    // overrun_clear works alone and loses against a simultaneous set.
    do_reset();
    run_seq("urgent_overrun", {rep("1", 40), rep("0", 1), rep("1", 24)},
            {rep("G", 40), rep("I", 1), rep("H", 1), rep("C", 1), rep("R", 3), rep("P", 2),
             rep("H", 1), rep("C", 1), rep("R", 3), rep("P", 2), rep("G", 10)},
            {rep("0", 8), rep("1", 8), rep("2", 8), rep("3", 8), rep("4", 14), rep("3", 2),
             rep("4", 5), rep("3", 3), rep("4", 9)},
            {rep("0", 57), rep("1", 1), rep("0", 5), rep("1", 1), rep("0", 1)},
            {rep("0", 40), rep("1", 18), rep("0", 6), rep("1", 1)});

    // Reset asserted mid-RAS releases strobes at once; first tick again 8 cycles after release.
    do_reset();
    run_seq("pre_reset", rep("0", 12),
            {rep("I", 9), rep("C", 1), rep("R", 2)},
            {rep("0", 8), rep("1", 4)}, "", "");
    chk("ras_before_reset", {12'h000, refresh_ras}, 16'h000F);
    #1 n_reset = 1'b0;
    #1;
    chk("reset_mid_ras", {1'b0, cpu_grant, cpu_hold, refresh_ras, refresh_cas,
                          refresh_busy, pending, overrun}, 16'h0000);
`ifdef SIMM_REFRESH_STATS_EN
    chk("count_after_reset", refresh_count, 16'd0);
`endif
    @(negedge clock);
    n_reset = 1'b1;
    run_seq("after_reset", rep("0", 15),
            {rep("I", 9), rep("C", 1), rep("R", 3), rep("P", 2)},
            {rep("0", 8), rep("1", 5), rep("0", 2)}, "", "");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
